// File: rtl/shift_step_engine.sv
// Sequential 2-bit-per-cycle left shifter behind a valid/ready handshake.
// Define SHIFT_STEP_OVF_EN to add the sticky shifted-out-bits flag (io_out_overflow).
module shift_step_engine (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_bits,
    input  logic [3:0]  io_in_steps,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_bits,
`ifdef SHIFT_STEP_OVF_EN
    output logic        io_out_overflow,
`endif
    output logic        io_busy
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  data;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] d);
        return {d[DATA_W-3:0], 2'b00};
    endfunction

    function automatic logic spill(input logic [DATA_W-1:0] d);
        return d[DATA_W-1:DATA_W-2] != 2'b00;
    endfunction

    assign accept      = (state == IDLE) && io_in_valid;
    assign io_out_bits = data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs decode straight from state so reset drops them without a clock edge
    always_comb begin
        state_next   = state;
        io_in_ready  = 1'b0;
        io_out_valid = 1'b0;
        io_busy      = 1'b0;
        case (state)
            IDLE: begin
                io_in_ready = 1'b1;
                if (io_in_valid) begin
                    state_next = (io_in_steps == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                io_busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                io_busy      = 1'b1;
                io_out_valid = 1'b1;
                if (io_out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data <= '0;
            cnt  <= '0;
        end else if (accept) begin
            data <= io_in_bits;
            cnt  <= io_in_steps;
        end else if (state == SHIFT) begin
            data <= shift_step(data);
            cnt  <= cnt - CNT_W'(1);
        end
    end

`ifdef SHIFT_STEP_OVF_EN
    logic ovf;

    // Sticky across the SHIFT phase, cleared only when a new word is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (state == SHIFT) begin
            ovf <= ovf | spill(data);
        end
    end

    assign io_out_overflow = ovf;
`endif

endmodule

// File: tb/tb_shift_step_engine.sv
// Self-checking bench for shift_step_engine: directed test-plan cases plus a
// randomized run compared every cycle against an arithmetic reference model.
module tb_shift_step_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_in_valid = 1'b0;
    logic        io_in_ready;
    logic [31:0] io_in_bits = '0;
    logic [3:0]  io_in_steps = '0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b0;
    logic [31:0] io_out_bits;
    logic        io_out_overflow;
    logic        io_busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    shift_step_engine dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_bits      (io_in_bits),
        .io_in_steps     (io_in_steps),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_bits     (io_out_bits),
`ifdef SHIFT_STEP_OVF_EN
        .io_out_overflow (io_out_overflow),
`endif
        .io_busy         (io_busy)
    );

`ifndef SHIFT_STEP_OVF_EN
    assign io_out_overflow = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the word accepted, how many steps it has taken so far,
    // and the result as plain 64-bit arithmetic on the original word.
    bit          m_busy = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:0] m_data = '0;
    logic        m_ovf  = 1'b0;
    int          m_n    = 0;
    int          m_j    = 0;

    function automatic logic [63:0] widened_shift(input logic [31:0] w, input int k);
        logic [63:0] e;
        e = {32'h0, w};
        return e << (2 * k);
    endfunction

    task automatic model_update();
        logic [63:0] e;
        e = widened_shift(m_word, m_j);
        m_data = e[31:0];
        m_ovf  = |e[63:32];
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_data = '0;
            m_ovf  = 1'b0;
        end else if (!m_busy) begin
            if (io_in_valid) begin
                m_busy = 1'b1;
                m_word = io_in_bits;
                m_n    = int'(io_in_steps);
                m_j    = 0;
                model_update();
            end
        end else if (m_j >= m_n) begin
            if (io_out_ready) m_busy = 1'b0;
        end else begin
            m_j++;
            model_update();
        end
    end

    always @(negedge clock) begin
        chk("in_ready",  32'(io_in_ready),  32'(!m_busy));
        chk("out_valid", 32'(io_out_valid), 32'(m_busy && (m_j >= m_n)));
        chk("busy",      32'(io_busy),      32'(m_busy));
        chk("out_bits",  io_out_bits,       m_data);
`ifdef SHIFT_STEP_OVF_EN
        chk("overflow",  32'(io_out_overflow), 32'(m_ovf));
`endif
    end

    // Pushes one word, measures latency, applies back-pressure, then drains.
    task automatic run_word(input logic [31:0] w, input logic [3:0] s, input int hold,
                            input bit pulse, output logic [31:0] res, output logic ov,
                            output int lat);
        int g;
        g = 0;
        while (!io_in_ready && g < 100) begin
            @(posedge clock); #1;
            g++;
        end
        if (g >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
        io_in_valid  = 1'b1;
        io_in_bits   = w;
        io_in_steps  = s;
        io_out_ready = 1'b0;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        lat = 1;
        while (!io_out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        if (lat >= 100) chk("out_valid_timeout", 32'd0, 32'd1);
        res = io_out_bits;
        ov  = io_out_overflow;
        chk("done_in_ready", 32'(io_in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                io_in_valid = 1'b1;
                io_in_bits  = $urandom;
                io_in_steps = 4'($urandom_range(0, 15));
            end
            @(posedge clock); #1;
            chk("hold_bits",  io_out_bits, res);
            chk("hold_valid", 32'(io_out_valid), 32'd1);
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock); #1;
        io_out_ready = 1'b0;
        chk("after_hs_ready", 32'(io_in_ready), 32'd1);
        chk("after_hs_valid", 32'(io_out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic        ov;
        int          lat;

        #1 reset = 1'b1;
        #2;
        chk("rst_in_ready",  32'(io_in_ready),  32'd1);
        chk("rst_out_valid", 32'(io_out_valid), 32'd0);
        chk("rst_out_bits",  io_out_bits,       32'd0);
        chk("rst_busy",      32'(io_busy),      32'd0);
        chk("rst_overflow",  32'(io_out_overflow), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        run_word(32'h0000_0001, 4'd3, 0, 1'b0, res, ov, lat);
        chk("basic_bits", res, 32'h0000_0040);
        chk("basic_lat",  32'(lat), 32'd4);
        chk("basic_ovf",  32'(ov), 32'd0);

        run_word(32'hC000_0000, 4'd1, 0, 1'b0, res, ov, lat);
        chk("ovf_bits", res, 32'h0000_0000);
`ifdef SHIFT_STEP_OVF_EN
        chk("ovf_flag", 32'(ov), 32'd1);
`endif
        run_word(32'h0000_0010, 4'd2, 0, 1'b0, res, ov, lat);
        chk("ovf_clr_bits", res, 32'h0000_0100);
        chk("ovf_clr_flag", 32'(ov), 32'd0);

        run_word(32'hDEAD_BEEC, 4'd0, 0, 1'b0, res, ov, lat);
        chk("zero_bits", res, 32'hDEAD_BEEC);
        chk("zero_lat",  32'(lat), 32'd1);

        run_word(32'h0000_0003, 4'd15, 5, 1'b1, res, ov, lat);
        chk("bp_bits", res, 32'hC000_0000);
        chk("bp_lat",  32'(lat), 32'd16);

        // Reset while shifting: handshake accepted in cycle 0, reset lands in cycle 4
        io_in_valid = 1'b1;
        io_in_bits  = 32'h0000_0001;
        io_in_steps = 4'd10;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk("mid_busy", 32'(io_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_in_ready", 32'(io_in_ready), 32'd1);
        chk("mr_busy",     32'(io_busy),     32'd0);
        chk("mr_out_bits", io_out_bits,      32'd0);
        chk("mr_ovf",      32'(io_out_overflow), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_word(32'h1234_5678, 4'd4, 2, 1'b0, res, ov, lat);
        chk("post_rst_bits", res, 32'h3456_7800);
        chk("post_rst_lat",  32'(lat), 32'd5);
`ifdef SHIFT_STEP_OVF_EN
        chk("post_rst_ovf",  32'(ov), 32'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            io_in_valid  = 1'($urandom_range(0, 1));
            io_in_bits   = $urandom;
            io_in_steps  = 4'($urandom_range(0, 15));
            io_out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        @(posedge clock); #1;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;
        @(posedge clock); #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
